result_uart_sender: RTL and testbench

//  Transmit side of the image/convolution UART link: holds the convolution result vector and

---
 rtl/bin_conv_pkg.sv | 24 ++
 rtl/result_buf.sv | 37 +++
 rtl/result_uart_sender.sv | 157 +++++++++++++++
 tb/tb_result_uart_sender.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_conv_pkg.sv
// Shared types for the convolution-result UART transmit path:
// sequencer states, frame byte selector and the default frame sync byte.
package bin_conv_pkg;

    // Sequencer states of the result sender.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_IDLE = 3'd3,
        DONE      = 3'd4
    } state_e;

    // Which field of the frame the current byte index points at.
    typedef enum logic [1:0] {
        SEL_SYNC    = 2'd0,
        SEL_LEN     = 2'd1,
        SEL_PAYLOAD = 2'd2,
        SEL_CHK     = 2'd3
    } byte_sel_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/result_buf.sv
// Result register file: NUM_RESULTS bytes, gated write port with
// out-of-range address rejection, combinational read by index.
module result_buf #(
    parameter int NUM_RESULTS = 10,
    parameter int AW          = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [NUM_RESULTS];

    // Storage: cleared on reset, written only for in-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i && (int'(waddr_i) < NUM_RESULTS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: out-of-range indices return zero rather than X.
    always_comb begin
        rdata_o = 8'h00;
        if (int'(raddr_i) < NUM_RESULTS) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/result_uart_sender.sv
// Result sender: streams SYNC, LEN, the result bytes and an XOR checksum
// to uart_tx one byte at a time over a tx_start/tx_busy handshake.
// Handshake: tx_start is a one-cycle request issued only while tx_busy is
// low; uart_tx acknowledges by raising tx_busy, and the byte is complete
// when tx_busy falls again. tx_data holds its value across that window.
module result_uart_sender
    import bin_conv_pkg::*;
#(
    parameter int         NUM_RESULTS = 10,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT = 16,
    localparam int        AW          = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          send,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          busy,
    output logic          done,
    output state_e        dbg_state_o
);

    localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [8:0] LAST_IDX = 9'(NUM_RESULTS + 2);
    localparam logic [7:0] LEN_BYTE = 8'(NUM_RESULTS);

    state_e         state_q;
    logic [8:0]     idx_q;
    logic [7:0]     chk_q;
    logic [TW-1:0]  timer_q;
    logic           tx_start_q;
    logic [7:0]     tx_data_q;
    logic           busy_q;
    logic           done_q;

    byte_sel_e      sel_d;
    logic [7:0]     byte_d;
    logic [7:0]     rd_data;
    logic [AW-1:0]  rd_addr;

    // The buffer is frozen for the whole frame: writes land only while idle.
    result_buf #(
        .NUM_RESULTS (NUM_RESULTS),
        .AW          (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en && !busy_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Map the byte index to its frame field and pick the byte to present.
    always_comb begin
        sel_d   = SEL_PAYLOAD;
        rd_addr = AW'(idx_q - 9'd2);
        byte_d  = rd_data;
        if (idx_q == 9'd0) begin
            sel_d = SEL_SYNC;
        end else if (idx_q == 9'd1) begin
            sel_d = SEL_LEN;
        end else if (idx_q == LAST_IDX) begin
            sel_d = SEL_CHK;
        end
        case (sel_d)
            SEL_SYNC: byte_d = SYNC_BYTE;
            SEL_LEN:  byte_d = LEN_BYTE;
            SEL_CHK:  byte_d = chk_q;
            default:  byte_d = rd_data;
        endcase
    end

    // Frame sequencer; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 9'd0;
            chk_q      <= 8'h00;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (send) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        idx_q   <= 9'd0;
                        chk_q   <= 8'h00;
                    end
                end
                LOAD: begin
                    // Hold off the request while uart_tx still reports busy.
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= byte_d;
                        timer_q    <= '0;
                        state_q    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    tx_start_q <= 1'b0;
                    if (tx_busy) begin
                        state_q <= WAIT_IDLE;
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        // No acknowledge: re-issue the same byte.
                        state_q <= LOAD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (!tx_busy) begin
                        // Checksum folds in bytes once uart_tx has finished them,
                        // so a re-pulsed byte is counted only once.
                        if (sel_d == SEL_LEN || sel_d == SEL_PAYLOAD) begin
                            chk_q <= chk_q ^ tx_data_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 9'd1;
                            state_q <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_uart_sender.sv
// Bench for result_uart_sender: models uart_tx (busy one cycle after a
// tx_start, held 20 cycles), scoreboards every frame byte.
module tb_result_uart_sender;

    localparam int NUM = 10;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       send;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] res_m [NUM];

    // uart_tx model controls
    int   busy_cnt;
    int   ignore_cnt = 0;
    logic force_busy = 1'b0;

    // monitor state
    int   pulse_cnt = 0;
    int   done_cnt  = 0;
    int   acked     = 0;
    logic pulse_seen = 1'b0;
    logic prev_busy  = 1'b0;

    result_uart_sender dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .send        (send),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // uart_tx model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (tx_start) begin
            if (ignore_cnt > 0) ignore_cnt <= ignore_cnt - 1;
            else busy_cnt <= 20;
        end
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            pulse_seen = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (tx_start) begin
                pulse_cnt++;
                check_eq("start_while_busy", 32'(tx_busy), 32'd0);
                if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(tx_data), 32'hFFFF);
                else check_eq("tx_byte", 32'(tx_data), 32'(exp_q[0]));
                pulse_seen = 1'b1;
            end else if (tx_busy && !prev_busy && pulse_seen) begin
                void'(exp_q.pop_front());
                acked++;
                pulse_seen = 1'b0;
            end
            prev_busy = tx_busy;
        end
    end

    // driver tasks
    task automatic write_res(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_send();
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic push_frame();
        logic [7:0] c;
        c = 8'(NUM);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NUM));
        for (int i = 0; i < NUM; i++) begin
            exp_q.push_back(res_m[i]);
            c ^= res_m[i];
        end
        exp_q.push_back(c);
    endtask

    task automatic wait_done(input string tag, input int start_done);
        int n;
        n = 0;
        while (done_cnt == start_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done_cnt - start_done), 32'd1);
        repeat (3) @(negedge clk);
        check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int p0, d0, a0, n;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; send = 1'b0;
        for (int i = 0; i < NUM; i++) res_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic frame, latency, pulse count
        for (int i = 0; i < NUM; i++) begin
            write_res(4'(i), 8'(i + 1));
            res_m[i] = 8'(i + 1);
        end
        push_frame();
        p0 = pulse_cnt; d0 = done_cnt;
        pulse_send();
        check_eq("t1_busy_after_send", 32'(busy), 32'd1);
        check_eq("t1_no_start_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        check_eq("t1_latency_start", 32'(tx_start), 32'd1);
        wait_done("t1_done", d0);
        check_eq("t1_pulses", 32'(pulse_cnt - p0), 32'd13);

        // 2: first request ignored, byte re-pulsed
        push_frame();
        p0 = pulse_cnt; d0 = done_cnt;
        ignore_cnt = 1;
        pulse_send();
        wait_done("t2_done", d0);
        check_eq("t2_pulses", 32'(pulse_cnt - p0), 32'd14);

        // 3: extra sends and a write during the frame are ignored
        push_frame();
        p0 = pulse_cnt; d0 = done_cnt;
        pulse_send();
        repeat (3) @(negedge clk);
        send = 1'b1; @(negedge clk); send = 1'b0;
        repeat (10) @(negedge clk);
        write_res(4'd3, 8'hFF);
        repeat (20) @(negedge clk);
        send = 1'b1; @(negedge clk); send = 1'b0;
        wait_done("t3_done", d0);
        repeat (100) @(negedge clk);
        check_eq("t3_pulses", 32'(pulse_cnt - p0), 32'd13);
        check_eq("t3_single_done", 32'(done_cnt - d0), 32'd1);

        // 4: reset during byte 6 aborts, buffer cleared
        push_frame();
        a0 = acked; d0 = done_cnt;
        pulse_send();
        n = 0;
        while (acked - a0 < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_reached_byte6", 32'(acked - a0), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t4_abort_start", 32'(tx_start), 32'd0);
        check_eq("t4_abort_busy", 32'(busy), 32'd0);
        check_eq("t4_abort_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("t4_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < NUM; i++) res_m[i] = 8'h00;
        push_frame();
        p0 = pulse_cnt; d0 = done_cnt;
        pulse_send();
        wait_done("t4_done", d0);
        check_eq("t4_pulses", 32'(pulse_cnt - p0), 32'd13);

        // 5: out-of-range write ignored; random legal writes
        write_res(4'd12, 8'h55);
        for (int k = 0; k < 3; k++) begin
            int a;
            logic [7:0] d;
            a = $urandom_range(0, NUM - 1);
            d = 8'($urandom_range(0, 255));
            write_res(4'(a), d);
            res_m[a] = d;
        end
        push_frame();
        d0 = done_cnt;
        pulse_send();
        wait_done("t5_done", d0);

        // 6: uart busy before send delays the first request
        @(negedge clk);
        force_busy = 1'b1;
        push_frame();
        p0 = pulse_cnt; d0 = done_cnt;
        repeat (5) @(negedge clk);
        pulse_send();
        repeat (23) @(negedge clk);
        check_eq("t6_held_off", 32'(pulse_cnt - p0), 32'd0);
        force_busy = 1'b0;
        wait_done("t6_done", d0);
        check_eq("t6_pulses", 32'(pulse_cnt - p0), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
